// File: rtl/adc_reader.sv
// -----------------------------------------------------------------------------
// adc_reader
//   Reads bursts of serial ADC words (MSB first) into a 2-entry output buffer.
//   The ADC only shifts while slp=0, so the reader can park the converter in
//   HOLD whenever the buffer is about to fill, and no ADC bit is ever lost.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst_adc     asynchronous, active-high reset
//   start       one-cycle burst request, ignored while busy
//   num_words   words in the burst, sampled when start is accepted
//   adc_dout    serial data from the ADC
//   slp         registered ADC sleep / clock gate (1 = ADC stopped)
//   word_data   head of the output buffer
//   word_valid  output buffer not empty
//   word_ready  consumer accept; pops when word_valid & word_ready
//   busy        reader is in SHIFT or HOLD
//   done        registered one-cycle pulse at burst completion
// -----------------------------------------------------------------------------
module adc_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_adc,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              adc_dout,
    output logic              slp,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    // Only the low DATA_W-1 bits are kept: the bit that would sit in the MSB
    // is shifted straight out into the pushed word and never needed again.
    logic [DATA_W-2:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  words_left, words_left_nxt;
    logic              slp_nxt;
    logic              done_nxt;

    // 2-entry output buffer
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count, count_nxt;

    logic              bit_last;
    logic              push, pop;
    logic [DATA_W-1:0] push_data;

    assign bit_last   = (bit_cnt == BIT_W'(DATA_W - 1));
    assign push_data  = {shreg, adc_dout};
    assign push       = (state == SHIFT) && bit_last;
    assign word_valid = (count != 2'd0);
    assign word_data  = fifo_mem[rd_ptr];
    assign pop        = word_valid && word_ready;
    // Occupancy after this edge; drives the HOLD entry/exit decision so the
    // buffer can never be pushed past two entries.
    assign count_nxt  = 2'(count + 2'(push) - 2'(pop));
    assign busy       = (state != IDLE);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        words_left_nxt = words_left;
        done_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        words_left_nxt = num_words;
                        bit_cnt_nxt    = '0;
                        shreg_nxt      = '0;
                        state_nxt      = SHIFT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            SHIFT: begin
                shreg_nxt = push_data[DATA_W-2:0];
                if (bit_last) begin
                    bit_cnt_nxt    = '0;
                    words_left_nxt = words_left - CNT_W'(1);
                end else begin
                    bit_cnt_nxt = bit_cnt + BIT_W'(1);
                end

                if (bit_last && (words_left == CNT_W'(1))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (count_nxt == 2'd2) begin
                    // Stop the ADC clock before the buffer would overflow;
                    // the bit sampled on this edge is already in shreg.
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (count_nxt < 2'd2) begin
                    state_nxt = SHIFT;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // slp is registered from the next state so the ADC clock gate changes on
    // the same edge as the state that owns it.
    assign slp_nxt = (state_nxt != SHIFT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst_adc) begin
        if (rst_adc) begin
            state      <= IDLE;
            slp        <= 1'b1;
            done       <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            words_left <= '0;
        end else begin
            state      <= state_nxt;
            slp        <= slp_nxt;
            done       <= done_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            words_left <= words_left_nxt;
        end
    end

    // NOTE: the buffer storage is reset (only two flop words) because
    // word_data is an observable output that must read zero during reset.
    always_ff @(posedge clk or posedge rst_adc) begin
        if (rst_adc) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_nxt;
        end
    end

endmodule
